bus_interconnect: RTL and testbench
===================================

// Module: bus_interconnect
// PURPOSE
//   Parametrised single-master, N-slave bus fabric between the CPU bus port and the
//   SoC peripherals/memories. Replaces hard-wired chip-select decode and data mux.
//   Registers each transaction, one-hot selects the matching slave, waits on that
//   slave's ready, and returns data to the CPU with a held valid/ready handshake.
//   Unmapped accesses complete with an error flag instead of hanging the CPU.
// PARAMETERS
//   NUM_SLAVES     4                  number of slave ports (1..16)
//   DATA_WIDTH     32                 bus data width
//   SLAVE_BASE     {NUM_SLAVES{32'h0}} packed NUM_SLAVES*32 base addresses; slot i = [32*i+:32]
//   SLAVE_MASK     {NUM_SLAVES{32'h0}} packed masks; slave i hit = (addr & mask_i) == base_i
//   TIMEOUT_CYCLES 255                wait-state limit per access (used only with BUS_TIMEOUT_EN)
//   ERROR_DATA     32'hDEADBEEF       read data returned on error completion
// PORTS
//   clk              in   1              system clock, all logic on rising edge
//   rst              in   1              synchronous reset, active-high
//   busAddress       in   32             master address
//   busDataIn        in   DATA_WIDTH     master write data
//   busWriteEnable   in   1              1 = write, 0 = read
//   busValid         in   1              master request; held until busReady seen
//   busReady         out  1              transaction complete; held while busValid stays 1
//   busDataOut       out  DATA_WIDTH     read data, valid while busReady=1
//   busError         out  1              with busReady: access unmapped or timed out
//   slaveSelect      out  NUM_SLAVES     one-hot chip select, at most one bit set
//   slaveAddress     out  32             registered address to slaves
//   slaveDataIn      out  DATA_WIDTH     registered write data to slaves
//   slaveWrite       out  1              registered write strobe, gated by slaveSelect
//   slaveDataOut     in   NUM_SLAVES*DW  packed slave read data; slot i = [DW*i+:DW]
//   slaveReady       in   NUM_SLAVES     per-slave ready; only selected bit is looked at
//   errorAddress     out  32             address of most recent error access
// BEHAVIOUR
//   - Reset (rst=1 at an edge): state=IDLE; busReady, busError, slaveSelect, slaveWrite=0;
//     busDataOut, slaveAddress, slaveDataIn, errorAddress=0; timeout counter=0.
//     Reset mid-transaction aborts it; no response is issued for the aborted access.
//   - FSM states: IDLE, ACCESS, DONE.
//   - IDLE: on busValid=1, latch address/write data/write enable. Decode priority: lowest
//     index hit wins. Hit -> ACCESS with slaveSelect[i]=1 from next cycle. No hit -> DONE
//     with busError=1, busDataOut=ERROR_DATA, errorAddress=busAddress.
//   - ACCESS: slaveSelect/slaveAddress/slaveDataIn/slaveWrite held stable. When
//     slaveReady[sel]=1: capture slaveDataOut slot sel into busDataOut (writes also
//     capture it), drop slaveSelect/slaveWrite, go DONE with busError=0.
//   - DONE: busReady=1, busDataOut and busError held. When busValid=0: busReady=0,
//     busError=0, go IDLE. A new request can be taken on the following cycle at the earliest.
//   - Latency: busValid at cycle 0 -> slaveSelect at 1; slaveReady at cycle k>=1 ->
//     busReady at k+1. Unmapped access: busReady at cycle 1.
//   - slaveReady on non-selected bits, and any slaveReady in IDLE/DONE, is ignored.
//   - busValid dropping during ACCESS: the slave access still completes. DONE then lasts
//     one cycle with busReady=1 and returns to IDLE.
// CONFIGURATION
//   BUS_TIMEOUT_EN defined: 8+ bit counter clears on entry to ACCESS and increments each
//     ACCESS cycle without ready. When count reaches TIMEOUT_CYCLES with no ready: drop
//     slaveSelect, go DONE with busError=1, busDataOut=ERROR_DATA, errorAddress=address.
//     If ready arrives in the same cycle the limit is reached, ready wins and no error is flagged.
//   BUS_TIMEOUT_EN undefined: no counter; ACCESS waits for slaveReady indefinitely.
// TESTING
//   1 Slave1 base 0x00010000 mask 0xFFFF0000, ready 1 cycle after select; read 0x00010004,
//     slave data 0x12345678 -> select=0010 at cyc1, busReady at cyc3, busDataOut=0x12345678, busError=0.
//   2 Write 0xF0000000 data 0xA5 to slave2 (mask 0xFFFFFFF8) -> slaveWrite=1, slaveDataIn=0xA5
//     for one cycle with ready; busReady held until busValid drops, then 0 next cycle.
//   3 Read 0x40000000 (no match) -> busReady at cyc1, busError=1, busDataOut=0xDEADBEEF,
//     errorAddress=0x40000000; no slaveSelect bit ever set.
//   4 Overlap: slave0 and slave3 both hit 0x00000010 -> only slaveSelect[0] asserted.
//   5 BUS_TIMEOUT_EN, TIMEOUT_CYCLES=8, slave never ready -> busError=1 with busReady after
//     8 ACCESS cycles; next access to a responsive slave completes normally.
//   6 rst=1 during ACCESS -> all outputs 0 next cycle; stale slaveReady after rst released is ignored.

Source files
------------

// File: rtl/bus_interconnect.sv
// ---------------------------------------------------------------------------
// bus_interconnect
//   Single-master, NUM_SLAVES-slave bus fabric. A CPU request is registered,
//   decoded against per-slave base/mask windows, and the lowest-index hit
//   slave is selected one-hot. The fabric waits for that slave's ready and
//   returns its read data to the CPU with a held valid/ready handshake.
//   Unmapped accesses complete immediately with busError set.
//
//   Optional feature macro: BUS_TIMEOUT_EN
//     defined   : an access waiting TIMEOUT_CYCLES cycles without ready is
//                 abandoned and completes with busError set.
//     undefined : the fabric waits on slaveReady indefinitely.
//
// Ports
//   clk, rst        clock (rising edge), synchronous active-high reset
//   busAddress      master address
//   busDataIn       master write data
//   busWriteEnable  1 = write, 0 = read
//   busValid        master request, held until busReady is seen
//   busReady        completion, held while busValid stays high
//   busDataOut      read data (valid with busReady)
//   busError        with busReady: unmapped or timed-out access
//   slaveSelect     one-hot chip select
//   slaveAddress    registered address to slaves
//   slaveDataIn     registered write data to slaves
//   slaveWrite      registered write strobe, only high with a select
//   slaveDataOut    packed slave read data, slot i = [DATA_WIDTH*i +: DATA_WIDTH]
//   slaveReady      per-slave ready, only the selected bit matters
//   errorAddress    address of the most recent error access
// ---------------------------------------------------------------------------

// Address window match for one slave.
module busAddrMatch #(
   parameter logic [31:0] BASE = 32'h0,
   parameter logic [31:0] MASK = 32'h0
) (
   input  logic [31:0] address,
   output logic        hit
);
   assign hit = ((address & MASK) == BASE);
endmodule

module bus_interconnect #(
   parameter int                        NUM_SLAVES     = 4,
   parameter int                        DATA_WIDTH     = 32,
   parameter logic [NUM_SLAVES*32-1:0]  SLAVE_BASE     = {NUM_SLAVES{32'h0}},
   parameter logic [NUM_SLAVES*32-1:0]  SLAVE_MASK     = {NUM_SLAVES{32'h0}},
   parameter int                        TIMEOUT_CYCLES = 255,
   parameter logic [DATA_WIDTH-1:0]     ERROR_DATA     = 32'hDEADBEEF
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic [31:0]                      busAddress,
   input  logic [DATA_WIDTH-1:0]            busDataIn,
   input  logic                             busWriteEnable,
   input  logic                             busValid,
   output logic                             busReady,
   output logic [DATA_WIDTH-1:0]            busDataOut,
   output logic                             busError,
   output logic [NUM_SLAVES-1:0]            slaveSelect,
   output logic [31:0]                      slaveAddress,
   output logic [DATA_WIDTH-1:0]            slaveDataIn,
   output logic                             slaveWrite,
   input  logic [NUM_SLAVES*DATA_WIDTH-1:0] slaveDataOut,
   input  logic [NUM_SLAVES-1:0]            slaveReady,
   output logic [31:0]                      errorAddress
);

   localparam logic [1:0] IDLE   = 2'd0;
   localparam logic [1:0] ACCESS = 2'd1;
   localparam logic [1:0] DONE   = 2'd2;

   logic [1:0]            state;
   logic [NUM_SLAVES-1:0] hitVec;
   logic [NUM_SLAVES-1:0] firstHit;
   logic [DATA_WIDTH-1:0] selData;
   logic                  slaveAck;

   // Per-slave window decode.
   for (genvar i = 0; i < NUM_SLAVES; i++) begin : gDecode
      busAddrMatch #(
         .BASE(SLAVE_BASE[32*i +: 32]),
         .MASK(SLAVE_MASK[32*i +: 32])
      ) uMatch (
         .address(busAddress),
         .hit    (hitVec[i])
      );
   end

   // Isolate the lowest set bit so overlapping windows resolve to the
   // lowest slave index.
   assign firstHit = hitVec & (~hitVec + NUM_SLAVES'(1));

   // Only the selected slave's ready is honoured; all others are masked.
   assign slaveAck = |(slaveSelect & slaveReady);

   always_comb begin
      selData = '0;
      for (int i = 0; i < NUM_SLAVES; i++)
         if (slaveSelect[i]) selData = slaveDataOut[DATA_WIDTH*i +: DATA_WIDTH];
   end

`ifdef BUS_TIMEOUT_EN
   localparam int TW = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
   logic [TW-1:0] timeoutCount;
   logic          timeoutHit;

   // Counter holds the number of completed wait cycles; this cycle would be
   // the TIMEOUT_CYCLES-th one.
   assign timeoutHit = ({1'b0, timeoutCount} + (TW+1)'(1)) >= (TW+1)'(TIMEOUT_CYCLES);
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= IDLE;
         busReady     <= 1'b0;
         busError     <= 1'b0;
         busDataOut   <= '0;
         slaveSelect  <= '0;
         slaveAddress <= '0;
         slaveDataIn  <= '0;
         slaveWrite   <= 1'b0;
         errorAddress <= '0;
`ifdef BUS_TIMEOUT_EN
         timeoutCount <= '0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (busValid) begin
                  slaveAddress <= busAddress;
                  slaveDataIn  <= busDataIn;
                  if (|hitVec) begin
                     slaveSelect <= firstHit;
                     slaveWrite  <= busWriteEnable;
                     state       <= ACCESS;
`ifdef BUS_TIMEOUT_EN
                     timeoutCount <= '0;
`endif
                  end else begin
                     // Unmapped: complete at once rather than hang the CPU.
                     busReady     <= 1'b1;
                     busError     <= 1'b1;
                     busDataOut   <= ERROR_DATA;
                     errorAddress <= busAddress;
                     state        <= DONE;
                  end
               end
            end

            ACCESS: begin
               // A ready on the limit cycle takes priority over the timeout.
               if (slaveAck) begin
                  busDataOut  <= selData;
                  slaveSelect <= '0;
                  slaveWrite  <= 1'b0;
                  busReady    <= 1'b1;
                  busError    <= 1'b0;
                  state       <= DONE;
               end
`ifdef BUS_TIMEOUT_EN
               else if (timeoutHit) begin
                  slaveSelect  <= '0;
                  slaveWrite   <= 1'b0;
                  busReady     <= 1'b1;
                  busError     <= 1'b1;
                  busDataOut   <= ERROR_DATA;
                  errorAddress <= slaveAddress;
                  state        <= DONE;
               end else begin
                  timeoutCount <= timeoutCount + TW'(1);
               end
`endif
            end

            DONE: begin
               // Response held until the master withdraws its request.
               if (!busValid) begin
                  busReady <= 1'b0;
                  busError <= 1'b0;
                  state    <= IDLE;
               end
            end

            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_bus_interconnect.sv
module tb_bus_interconnect;

   localparam int NS = 4;
   localparam int DW = 32;
   // slave3 overlaps slave0 at 0x10; slave2 is a small 8-byte window.
   localparam logic [NS*32-1:0] BASES = {32'h00000010, 32'hF0000000, 32'h00010000, 32'h00000000};
   localparam logic [NS*32-1:0] MASKS = {32'hFFFFFFF0, 32'hFFFFFFF8, 32'hFFFF0000, 32'hFFFFFF00};

   logic              clk, rst;
   logic [31:0]       busAddress;
   logic [DW-1:0]     busDataIn;
   logic              busWriteEnable, busValid;
   logic              busReady, busError;
   logic [DW-1:0]     busDataOut;
   logic [NS-1:0]     slaveSelect;
   logic [31:0]       slaveAddress;
   logic [DW-1:0]     slaveDataIn;
   logic              slaveWrite;
   logic [NS*DW-1:0]  slaveDataOut;
   logic [NS-1:0]     slaveReady;
   logic [31:0]       errorAddress;

   bus_interconnect #(
      .NUM_SLAVES(NS), .DATA_WIDTH(DW), .SLAVE_BASE(BASES), .SLAVE_MASK(MASKS),
      .TIMEOUT_CYCLES(8), .ERROR_DATA(32'hDEADBEEF)
   ) dut (
      .clk(clk), .rst(rst), .busAddress(busAddress), .busDataIn(busDataIn),
      .busWriteEnable(busWriteEnable), .busValid(busValid), .busReady(busReady),
      .busDataOut(busDataOut), .busError(busError), .slaveSelect(slaveSelect),
      .slaveAddress(slaveAddress), .slaveDataIn(slaveDataIn), .slaveWrite(slaveWrite),
      .slaveDataOut(slaveDataOut), .slaveReady(slaveReady), .errorAddress(errorAddress)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed { logic [DW-1:0] data; logic err; } resp_t;
   resp_t expQ[$];
   int checks = 0, errors = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // ---- slave models: ready asserted lat cycles after select rises ----
   int            lat[NS];
   logic          never[NS];
   logic          forceReady;
   logic [DW-1:0] sdata[NS];
   int            selCnt[NS];
   logic [NS-1:0] readyNext;

   always_comb begin
      slaveDataOut = '0;
      for (int i = 0; i < NS; i++) slaveDataOut[DW*i +: DW] = sdata[i];
   end

   always @(posedge clk)
      for (int i = 0; i < NS; i++) selCnt[i] <= (slaveSelect[i] === 1'b1) ? selCnt[i] + 1 : 0;

   always @(posedge clk) begin
      #1;
      for (int i = 0; i < NS; i++)
         readyNext[i] = (slaveSelect[i] === 1'b1) && !never[i] && (selCnt[i] >= lat[i]);
      slaveReady = forceReady ? '1 : readyNext;
   end

   // ---- scoreboard monitor: pop on each new response ----
   logic prevReady = 1'b0;
   always @(negedge clk) begin
      resp_t e;
      if (busReady === 1'b1 && !prevReady) begin
         if (expQ.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_response: got data %0h err %0b expected none", busDataOut, busError);
         end else begin
            e = expQ.pop_front();
            chk("resp_data", busDataOut, e.data);
            chk("resp_err", busError, e.err);
         end
      end
      prevReady = (busReady === 1'b1);
   end

   logic          lastWr;
   logic [DW-1:0] lastDin;

   task automatic access(input string name, input logic [31:0] a, input logic [DW-1:0] d,
                         input logic we, input logic [NS-1:0] expSel, input int expLat,
                         input logic [DW-1:0] expD, input logic expE, input int hold);
      int n;
      logic [NS-1:0] seen;
      resp_t r;
      r.data = expD; r.err = expE;
      expQ.push_back(r);
      busAddress = a; busDataIn = d; busWriteEnable = we; busValid = 1'b1;
      n = 0; seen = '0;
      while (busReady !== 1'b1 && n < 200) begin
         @(negedge clk);
         n++;
         seen |= slaveSelect;
         if (n == 1) chk({name, "_sel_cyc1"}, slaveSelect, expSel);
         if (|(slaveReady & slaveSelect)) begin lastWr = slaveWrite; lastDin = slaveDataIn; end
      end
      chk({name, "_latency"}, n, expLat);
      chk({name, "_sel_seen"}, seen, expSel);
      repeat (hold) begin
         @(negedge clk);
         chk({name, "_ready_held"}, busReady, 1'b1);
         chk({name, "_err_held"}, busError, expE);
      end
      busValid = 1'b0;
      @(negedge clk);
      chk({name, "_ready_drop"}, busReady, 1'b0);
      chk({name, "_err_drop"}, busError, 1'b0);
   endtask

   task automatic chkIdleZero(input string name);
      chk({name, "_ready"}, busReady, 1'b0);
      chk({name, "_err"}, busError, 1'b0);
      chk({name, "_sel"}, slaveSelect, '0);
      chk({name, "_wr"}, slaveWrite, 1'b0);
      chk({name, "_dout"}, busDataOut, '0);
      chk({name, "_saddr"}, slaveAddress, '0);
      chk({name, "_sdin"}, slaveDataIn, '0);
      chk({name, "_eaddr"}, errorAddress, '0);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      resp_t r;
      rst = 1'b1; busValid = 1'b0; busAddress = '0; busDataIn = '0; busWriteEnable = 1'b0;
      forceReady = 1'b0; slaveReady = '0; lastWr = 1'b0; lastDin = '0;
      lat   = '{2, 1, 1, 1};
      never = '{1'b0, 1'b0, 1'b0, 1'b0};
      sdata = '{32'h0000AAAA, 32'h12345678, 32'h000000C3, 32'h33333333};
      repeat (3) @(negedge clk);
      chkIdleZero("reset");
      rst = 1'b0;
      @(negedge clk);

      // 1: read slave1, ready one cycle after select -> busReady at cycle 3
      access("t1_read", 32'h00010004, '0, 1'b0, 4'b0010, 3, 32'h12345678, 1'b0, 1);

      // 2: write slave2; write strobe and data seen in the ready cycle
      access("t2_write", 32'hF0000000, 32'hA5, 1'b1, 4'b0100, 3, 32'h000000C3, 1'b0, 2);
      chk("t2_slaveWrite", lastWr, 1'b1);
      chk("t2_slaveDataIn", lastDin, 32'hA5);
      chk("t2_wr_dropped", slaveWrite, 1'b0);

      // 3: unmapped read completes at cycle 1 with error
      access("t3_unmapped", 32'h40000000, '0, 1'b0, 4'b0000, 1, 32'hDEADBEEF, 1'b1, 1);
      chk("t3_errorAddress", errorAddress, 32'h40000000);

      // 4: overlapping windows -> lowest index wins (slave0 latency 2)
      access("t4_overlap", 32'h00000010, '0, 1'b0, 4'b0001, 4, 32'h0000AAAA, 1'b0, 1);
      chk("t4_errorAddress_kept", errorAddress, 32'h40000000);

`ifdef BUS_TIMEOUT_EN
      // 5: slave1 never ready -> error after 8 access cycles, then recovery
      never[1] = 1'b1;
      access("t5_timeout", 32'h00010008, '0, 1'b0, 4'b0010, 9, 32'hDEADBEEF, 1'b1, 1);
      chk("t5_errorAddress", errorAddress, 32'h00010008);
      never[1] = 1'b0;
      access("t5_recover", 32'h00010004, '0, 1'b0, 4'b0010, 3, 32'h12345678, 1'b0, 1);
`else
      // 5: without timeout a slow slave is simply waited on
      lat[2] = 20;
      access("t5_longwait", 32'hF0000004, '0, 1'b0, 4'b0100, 22, 32'h000000C3, 1'b0, 1);
      lat[2] = 1;
`endif

      // busValid dropped during ACCESS: access still completes, one-cycle DONE
      lat[1] = 3;
      r.data = 32'h12345678; r.err = 1'b0;
      expQ.push_back(r);
      busAddress = 32'h00010000; busWriteEnable = 1'b0; busValid = 1'b1;
      @(negedge clk); @(negedge clk);
      busValid = 1'b0;
      n = 2;
      while (busReady !== 1'b1 && n < 200) begin @(negedge clk); n++; end
      chk("t7_latency", n, 5);
      @(negedge clk);
      chk("t7_one_cycle_done", busReady, 1'b0);
      lat[1] = 1;

      // 6: reset during ACCESS aborts with no response; stale ready ignored
      never[1] = 1'b1;
      busAddress = 32'h00010000; busValid = 1'b1;
      @(negedge clk); @(negedge clk);
      chk("t6_in_access_sel", slaveSelect, 4'b0010);
      rst = 1'b1; busValid = 1'b0;
      @(negedge clk);
      chkIdleZero("t6_reset");
      rst = 1'b0; never[1] = 1'b0; forceReady = 1'b1;
      repeat (3) begin
         @(negedge clk);
         chk("t6_stale_ready", busReady, 1'b0);
         chk("t6_stale_sel", slaveSelect, '0);
      end
      forceReady = 1'b0;
      @(negedge clk);
      access("t6_after", 32'h00010004, '0, 1'b0, 4'b0010, 3, 32'h12345678, 1'b0, 1);

      chk("queue_empty", expQ.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
